// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
// Error-distance statistics stage for 8x8 approximate multipliers.
// Accepts (a, b, y) samples over valid/ready, recomputes the exact product
// and accumulates ED metrics (error count, saturating sum, max) over a
// programmed run length.
// Optional feature macro: ERR_SQ_EN adds sum_sq_ed, a saturating sum of ED^2.
module approx_mult_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*W-1:0]     max_ed,
  output logic               sat
`ifdef ERR_SQ_EN
  ,
  output logic [ACC_W-1:0]   sum_sq_ed
`endif
);

  localparam int PW    = 2 * W;
  localparam int SQ_W  = 4 * W;
  // Adder wide enough for either the accumulator or the widest increment, plus carry
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] n_lat;
  logic             accept;
  logic             last_acc;
  logic             clr;

  logic [PW-1:0]    exact_p1;
  logic [PW-1:0]    y_p1;
  logic             vld_p1;

  logic [PW-1:0]    ed;
  logic [ACC_W:0]   sum_ed_add;
`ifdef ERR_SQ_EN
  logic [SQ_W-1:0]  ed_sq;
  logic [ACC_W:0]   sum_sq_add;
`endif

  // Unsigned |x - z| without relying on a signed intermediate
  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x,
                                             input logic [PW-1:0] z);
    if (x >= z) return x - z;
    else        return z - x;
  endfunction

  // Saturating accumulate; MSB of the result flags that the clamp engaged
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [SQ_W-1:0]  inc);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] lim;
    s   = SUM_W'(acc) + SUM_W'(inc);
    lim = SUM_W'({ACC_W{1'b1}});
    if (s > lim) return {1'b1, {ACC_W{1'b1}}};
    else         return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign accept   = in_valid & in_ready;
  assign last_acc = accept && ((sample_cnt + CNT_W'(1)) == n_lat);
  assign clr      = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured when no run is in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:        if (last_acc) state_nxt = DRAIN;
      DRAIN:      if (!vld_p1) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready = (state == RUN) && (sample_cnt < n_lat);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  // ---- Stage 1: capture exact product and approximate result on accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      exact_p1 <= '0;
      y_p1     <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        exact_p1 <= PW'(a) * PW'(b);
        y_p1     <= y;
      end
    end
  end

  // ---- Stage 2: error distance and statistics update ----
  always_comb begin
    ed         = abs_diff(exact_p1, y_p1);
    sum_ed_add = sat_add(sum_ed, SQ_W'(ed));
`ifdef ERR_SQ_EN
    ed_sq      = SQ_W'(ed) * SQ_W'(ed);
    sum_sq_add = sat_add(sum_sq_ed, ed_sq);
`endif
  end

  // Run length latch, sample counter and ED statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat      <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
      sat        <= 1'b0;
`ifdef ERR_SQ_EN
      sum_sq_ed  <= '0;
`endif
    end else if (clr) begin
      n_lat      <= num_samples;
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
      sat        <= 1'b0;
`ifdef ERR_SQ_EN
      sum_sq_ed  <= '0;
`endif
    end else begin
      if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
      if (vld_p1) begin
        if (ed != '0) err_cnt <= err_cnt + CNT_W'(1);
        sum_ed <= sum_ed_add[ACC_W-1:0];
        if (ed > max_ed) max_ed <= ed;
`ifdef ERR_SQ_EN
        sum_sq_ed <= sum_sq_add[ACC_W-1:0];
        if (sum_ed_add[ACC_W] || sum_sq_add[ACC_W]) sat <= 1'b1;
`else
        if (sum_ed_add[ACC_W]) sat <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor: default instance (ACC_W=32)
// plus a narrow-accumulator instance (ACC_W=12) sharing the same stimulus.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  a, b;
  logic [15:0] y;

  logic        in_ready, busy, done, sat;
  logic [15:0] sample_cnt, err_cnt, max_ed;
  logic [31:0] sum_ed;

  logic        in_ready12, busy12, done12, sat12;
  logic [15:0] sample_cnt12, err_cnt12, max_ed12;
  logic [11:0] sum_ed12;
`ifdef ERR_SQ_EN
  logic [31:0] sum_sq_ed;
  logic [11:0] sum_sq_ed12;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mult_err_monitor #(.W(8), .CNT_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed), .sat(sat)
`ifdef ERR_SQ_EN
    , .sum_sq_ed(sum_sq_ed)
`endif
  );

  approx_mult_err_monitor #(.W(8), .CNT_W(16), .ACC_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready12), .a(a), .b(b), .y(y),
    .busy(busy12), .done(done12), .sample_cnt(sample_cnt12), .err_cnt(err_cnt12),
    .sum_ed(sum_ed12), .max_ed(max_ed12), .sat(sat12)
`ifdef ERR_SQ_EN
    , .sum_sq_ed(sum_sq_ed12)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},   64'(in_ready),   64'd0);
    chk({tag, ".busy"},       64'(busy),       64'd0);
    chk({tag, ".done"},       64'(done),       64'd0);
    chk({tag, ".sample_cnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, ".err_cnt"},    64'(err_cnt),    64'd0);
    chk({tag, ".sum_ed"},     64'(sum_ed),     64'd0);
    chk({tag, ".max_ed"},     64'(max_ed),     64'd0);
    chk({tag, ".sat"},        64'(sat),        64'd0);
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] yy);
    in_valid = v;
    a        = aa;
    b        = bb;
    y        = yy;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = '0;
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_idle("reset");

    // 1: reset asserted mid-run clears everything
    do_start(16'd3);
    chk("t1.busy", 64'(busy), 64'd1);
    chk("t1.in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 8'd10, 8'd10, 16'd0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    chk("t1.sum_partial", 64'(sum_ed), 64'd100);
    rst_n = 1'b0;
    #1;
    chk_idle("t1.async");
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("t1.release");

    // 2: exact samples back-to-back
    do_start(16'd3);
    drive(1'b1, 8'd5, 8'd3, 16'd15);        tick();
    drive(1'b1, 8'd255, 8'd255, 16'd65025); tick();
    drive(1'b1, 8'd123, 8'd45, 16'd5535);   tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    chk("t2.in_ready_drain", 64'(in_ready), 64'd0);
    chk("t2.busy_drain", 64'(busy), 64'd1);
    tick();
    chk("t2.done_k1", 64'(done), 64'd0);
    tick();
    chk("t2.done", 64'(done), 64'd1);
    chk("t2.busy", 64'(busy), 64'd0);
    chk("t2.sample_cnt", 64'(sample_cnt), 64'd3);
    chk("t2.err_cnt", 64'(err_cnt), 64'd0);
    chk("t2.sum_ed", 64'(sum_ed), 64'd0);
    chk("t2.max_ed", 64'(max_ed), 64'd0);

    // 3: two erroneous samples: ED 1000 and 7
    do_start(16'd2);
    chk("t3.cleared_cnt", 64'(sample_cnt), 64'd0);
    drive(1'b1, 8'd200, 8'd150, 16'd29000); tick();
    drive(1'b1, 8'd17, 8'd19, 16'd330);     tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick(); tick();
    chk("t3.done", 64'(done), 64'd1);
    chk("t3.err_cnt", 64'(err_cnt), 64'd2);
    chk("t3.sum_ed", 64'(sum_ed), 64'd1007);
    chk("t3.max_ed", 64'(max_ed), 64'd1000);
    chk("t3.sat", 64'(sat), 64'd0);
`ifdef ERR_SQ_EN
    chk("t3.sum_sq_ed", 64'(sum_sq_ed), 64'd1000049);
`endif

    // 4: gapped valid; invalid cycles carry a large error that must not count
    do_start(16'd4);
    drive(1'b1, 8'd2, 8'd3, 16'd7);       tick();
    drive(1'b0, 8'd255, 8'd255, 16'd0);   tick();
    chk("t4.cnt_gap", 64'(sample_cnt), 64'd1);
    drive(1'b1, 8'd4, 8'd4, 16'd15);      tick();
    drive(1'b1, 8'd6, 8'd7, 16'd43);      tick();
    drive(1'b0, 8'd255, 8'd255, 16'd0);   tick();
    drive(1'b1, 8'd9, 8'd9, 16'd80);      tick();
    drive(1'b1, 8'd255, 8'd255, 16'd0);
    chk("t4.in_ready_after", 64'(in_ready), 64'd0);
    tick();
    chk("t4.done_k1", 64'(done), 64'd0);
    tick();
    chk("t4.done_k2", 64'(done), 64'd1);
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    chk("t4.sample_cnt", 64'(sample_cnt), 64'd4);
    chk("t4.err_cnt", 64'(err_cnt), 64'd4);
    chk("t4.sum_ed", 64'(sum_ed), 64'd4);
    chk("t4.max_ed", 64'(max_ed), 64'd1);

    // 5: saturation on the 12-bit accumulator; start during RUN is ignored
    do_start(16'd5);
    drive(1'b1, 8'd0, 8'd0, 16'd1000); tick();
    tick();
    start = 1'b1; num_samples = 16'd1;
    tick();
    start = 1'b0;
    tick(); tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick(); tick();
    chk("t5.done12", 64'(done12), 64'd1);
    chk("t5.sample_cnt12", 64'(sample_cnt12), 64'd5);
    chk("t5.sum_ed12", 64'(sum_ed12), 64'd4095);
    chk("t5.sat12", 64'(sat12), 64'd1);
    chk("t5.max_ed12", 64'(max_ed12), 64'd1000);
    chk("t5.sum_ed32", 64'(sum_ed), 64'd5000);
    chk("t5.sat32", 64'(sat), 64'd0);

    // 6: zero-length run, then a clean re-run
    drive(1'b1, 8'd1, 8'd1, 16'd9);
    do_start(16'd0);
    chk("t6.done", 64'(done), 64'd1);
    chk("t6.in_ready", 64'(in_ready), 64'd0);
    chk("t6.sample_cnt", 64'(sample_cnt), 64'd0);
    chk("t6.sum_ed12", 64'(sum_ed12), 64'd0);
    chk("t6.sat12", 64'(sat12), 64'd0);
    chk("t6.max_ed", 64'(max_ed), 64'd0);
    tick();
    chk("t6.cnt_hold", 64'(sample_cnt), 64'd0);
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    do_start(16'd1);
    chk("t6.rerun_busy", 64'(busy), 64'd1);
    drive(1'b1, 8'd3, 8'd4, 16'd12); tick();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    tick(); tick();
    chk("t6.rerun_done", 64'(done), 64'd1);
    chk("t6.rerun_cnt", 64'(sample_cnt), 64'd1);
    chk("t6.rerun_err", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
